// File: rtl/uart_pkg.sv
// Shared UART definitions: parity and receiver state encodings,
// tuser bit positions and the minimum supported word size.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_ODD  = 2'b01,
      PAR_EVEN = 2'b10
   } par_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2,
      ST_BRKWAIT
   } rx_state_e;

   localparam int TUSER_PAR = 0;
   localparam int TUSER_FRM = 1;
   localparam int TUSER_BRK = 2;

   localparam int MIN_DATA_BITS = 5;

   // The spare 2'b11 code behaves as "no parity".
   function automatic par_e par_decode(input logic [1:0] raw);
      case (raw)
         2'b01:   return PAR_ODD;
         2'b10:   return PAR_EVEN;
         default: return PAR_NONE;
      endcase
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Prescaled oversample tick generator with a per-bit phase counter,
// restartable so the phase aligns to a detected start edge.
module uart_baud_tick #(
   parameter int OVERSAMPLE     = 16,
   parameter int PRESCALE_WIDTH = 16,
   parameter int PHASE_WIDTH    = $clog2(OVERSAMPLE)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      restart,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic                      tick,
   output logic [PHASE_WIDTH-1:0]    phase
);
   import uart_pkg::*;

   localparam logic [PHASE_WIDTH-1:0] PHASE_LAST =
      PHASE_WIDTH'(OVERSAMPLE - 1);

   logic [PRESCALE_WIDTH-1:0] cnt_q;
   logic [PRESCALE_WIDTH-1:0] reload;

   // A prescale of zero behaves like one: a tick every clock.
   assign reload = (prescale == '0) ? '0
                 : prescale - PRESCALE_WIDTH'(1);

   assign tick = (cnt_q == '0) && !restart;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         phase <= '0;
      end else if (restart) begin
         cnt_q <= reload;
         phase <= '0;
      end else if (cnt_q == '0) begin
         cnt_q <= reload;
         phase <= (phase == PHASE_LAST) ? '0
                : phase + PHASE_WIDTH'(1);
      end else begin
         cnt_q <= cnt_q - PRESCALE_WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver with majority-voted sampling,
// per-word error flags and a single-entry AXI4-Stream output.
module uart_rx_cfg #(
   parameter int DATA_WIDTH     = 9,
   parameter int OVERSAMPLE     = 16,
   parameter int PRESCALE_WIDTH = 16,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rxd,
   output logic [DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [2:0]                m_axis_tuser,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      busy,
   output logic                      overrun_error,
   output logic                      frame_error,
   output logic                      parity_error,
   output logic                      break_detect,
   input  logic [PRESCALE_WIDTH-1:0] cfg_prescale,
   input  logic [3:0]                cfg_data_bits,
   input  logic [1:0]                cfg_parity,
   input  logic                      cfg_stop_bits
);
   import uart_pkg::*;

   localparam int PW = $clog2(OVERSAMPLE);
   localparam logic [PW-1:0] PH_S0  = PW'(OVERSAMPLE / 2 - 1);
   localparam logic [PW-1:0] PH_S1  = PW'(OVERSAMPLE / 2);
   localparam logic [PW-1:0] PH_RES = PW'(OVERSAMPLE / 2 + 1);
   localparam logic [3:0] MAX_BITS  = 4'(DATA_WIDTH);
   localparam logic [3:0] MIN_BITS  = 4'(MIN_DATA_BITS);

   rx_state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_s, rxd_q;
   logic                   start_edge;

   logic          tick;
   logic [PW-1:0] phase;
   logic          s0_q, s1_q;
   logic          bit_done, vote;

   logic [3:0] nbits_q;
   par_e       par_q;
   logic       stop2_q;
   logic       cfg_ok;

   logic [DATA_WIDTH-1:0] shreg_q;
   logic [3:0]            bit_cnt_q;
   logic                  par_acc_q, par_err_q;
   logic                  frm_q, zero_q;
   logic                  frm_fin, zero_fin, last_data;
   logic                  done;
   logic [2:0]            user_fin;

   assign rxd_s      = sync_q[SYNC_STAGES-1];
   assign start_edge = (state_q == ST_IDLE) && rxd_q && !rxd_s;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= '1;
         rxd_q  <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
         rxd_q  <= rxd_s;
      end
   end

   uart_baud_tick #(
      .OVERSAMPLE     (OVERSAMPLE),
      .PRESCALE_WIDTH (PRESCALE_WIDTH),
      .PHASE_WIDTH    (PW)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .restart  (start_edge),
      .prescale (cfg_prescale),
      .tick     (tick),
      .phase    (phase)
   );

   // Third sample is the live synced input at the resolve tick.
   assign bit_done = tick && (phase == PH_RES);
   assign vote     = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);

   assign cfg_ok    = (cfg_data_bits >= MIN_BITS)
                   && (cfg_data_bits <= MAX_BITS);
   assign last_data = (bit_cnt_q == nbits_q - 4'd1);
   assign frm_fin   = frm_q | ~vote;
   assign zero_fin  = zero_q & ~vote;

   assign user_fin[TUSER_BRK] = zero_fin;
   assign user_fin[TUSER_FRM] = frm_fin;
   assign user_fin[TUSER_PAR] = par_err_q & ~zero_fin;

   assign busy = (state_q != ST_IDLE);

   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      unique case (state_q)
         ST_IDLE:
            if (start_edge) state_d = ST_START;
         ST_START:
            if (bit_done) state_d = vote ? ST_IDLE : ST_DATA;
         ST_DATA:
            if (bit_done && last_data)
               state_d = (par_q == PAR_NONE) ? ST_STOP1 : ST_PARITY;
         ST_PARITY:
            if (bit_done) state_d = ST_STOP1;
         ST_STOP1:
            if (bit_done) begin
               if (stop2_q) begin
                  state_d = ST_STOP2;
               end else begin
                  done    = 1'b1;
                  state_d = zero_fin ? ST_BRKWAIT : ST_IDLE;
               end
            end
         ST_STOP2:
            if (bit_done) begin
               done    = 1'b1;
               state_d = zero_fin ? ST_BRKWAIT : ST_IDLE;
            end
         ST_BRKWAIT:
            if (rxd_s) state_d = ST_IDLE;
         default:
            state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s0_q      <= 1'b0;
         s1_q      <= 1'b0;
         nbits_q   <= '0;
         par_q     <= PAR_NONE;
         stop2_q   <= 1'b0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         par_acc_q <= 1'b0;
         par_err_q <= 1'b0;
         frm_q     <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         if (tick && phase == PH_S0) s0_q <= rxd_s;
         if (tick && phase == PH_S1) s1_q <= rxd_s;
         if (start_edge) begin
            nbits_q   <= cfg_ok ? cfg_data_bits : MAX_BITS;
            par_q     <= par_decode(cfg_parity);
            stop2_q   <= cfg_stop_bits;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            par_acc_q <= 1'b0;
            par_err_q <= 1'b0;
            frm_q     <= 1'b0;
            zero_q    <= 1'b1;
         end else if (bit_done) begin
            case (state_q)
               ST_DATA: begin
                  shreg_q   <= shreg_q
                             | (DATA_WIDTH'(vote) << bit_cnt_q);
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  par_acc_q <= par_acc_q ^ vote;
                  zero_q    <= zero_fin;
               end
               ST_PARITY: begin
                  par_err_q <= par_acc_q ^ vote ^ (par_q == PAR_ODD);
                  zero_q    <= zero_fin;
               end
               ST_STOP1, ST_STOP2: begin
                  frm_q  <= frm_fin;
                  zero_q <= zero_fin;
               end
               default: ;
            endcase
         end
      end
   end

   // A completed word is dropped, not queued, if the slot is still held.
   always_ff @(posedge clk) begin
      if (!rst) begin
         m_axis_tdata  <= '0;
         m_axis_tuser  <= '0;
         m_axis_tvalid <= 1'b0;
         overrun_error <= 1'b0;
         frame_error   <= 1'b0;
         parity_error  <= 1'b0;
         break_detect  <= 1'b0;
      end else begin
         overrun_error <= 1'b0;
         frame_error   <= 1'b0;
         parity_error  <= 1'b0;
         break_detect  <= 1'b0;
         if (done) begin
            break_detect <= user_fin[TUSER_BRK];
            frame_error  <= user_fin[TUSER_FRM];
            parity_error <= user_fin[TUSER_PAR];
            if (m_axis_tvalid && !m_axis_tready) begin
               overrun_error <= 1'b1;
            end else begin
               m_axis_tdata  <= shreg_q;
               m_axis_tuser  <= user_fin;
               m_axis_tvalid <= 1'b1;
            end
         end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed and randomized frames for uart_rx_cfg, checked against a
// frame-level reference model of the received word and its flags.
module tb_uart_rx_cfg;

   localparam int DW = 9;
   localparam int OS = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rxd = 1'b1;
   logic [DW-1:0] m_axis_tdata;
   logic [2:0]    m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          busy;
   logic          overrun_error, frame_error;
   logic          parity_error, break_detect;
   logic [15:0]   cfg_prescale = 16'd4;
   logic [3:0]    cfg_data_bits = 4'd8;
   logic [1:0]    cfg_parity = 2'b00;
   logic          cfg_stop_bits = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int n_ovr = 0, n_frm = 0, n_par = 0, n_brk = 0, got_n = 0;
   int b_ovr, b_frm, b_par, b_brk;
   logic [DW+2:0] got [0:255];
   int fb [0:31];
   int fb_len = 0;
   int bit_clk = 64;

   uart_rx_cfg #(
      .DATA_WIDTH     (DW),
      .OVERSAMPLE     (OS),
      .PRESCALE_WIDTH (16),
      .SYNC_STAGES    (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .rxd           (rxd),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .busy          (busy),
      .overrun_error (overrun_error),
      .frame_error   (frame_error),
      .parity_error  (parity_error),
      .break_detect  (break_detect),
      .cfg_prescale  (cfg_prescale),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity    (cfg_parity),
      .cfg_stop_bits (cfg_stop_bits)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (m_axis_tvalid && m_axis_tready) begin
         got[got_n % 256] <= {m_axis_tuser, m_axis_tdata};
         got_n <= got_n + 1;
      end
      n_ovr <= n_ovr + int'(overrun_error);
      n_frm <= n_frm + int'(frame_error);
      n_par <= n_par + int'(parity_error);
      n_brk <= n_brk + int'(break_detect);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      b_ovr = n_ovr;
      b_frm = n_frm;
      b_par = n_par;
      b_brk = n_brk;
   endtask

   // Pulse counts since snap(), packed {ovr, brk, frm, par}.
   function automatic logic [31:0] errs();
      return {8'(n_ovr - b_ovr), 8'(n_brk - b_brk),
              8'(n_frm - b_frm), 8'(n_par - b_par)};
   endfunction

   task automatic set_cfg(input int nb, input int par, input int st);
      cfg_data_bits = 4'(nb);
      cfg_parity    = 2'(par);
      cfg_stop_bits = 1'(st);
   endtask

   // Line levels after the start bit: data LSB first, parity, stops.
   task automatic build(input int nb, input int par, input int st,
                        input int data, input bit bad_par,
                        input bit bad_stop);
      int ones, k, p;
      ones = 0;
      k = 0;
      for (int i = 0; i < nb; i++) begin
         fb[k] = (data >> i) & 1;
         ones += fb[k];
         k++;
      end
      if (par == 1 || par == 2) begin
         p = (par == 1) ? 1 - (ones % 2) : ones % 2;
         if (bad_par) p = 1 - p;
         fb[k] = p;
         k++;
      end
      fb[k] = (st == 0 && bad_stop) ? 0 : 1;
      k++;
      if (st != 0) begin
         fb[k] = bad_stop ? 0 : 1;
         k++;
      end
      fb_len = k;
   endtask

   // Config inputs are scrambled mid-frame; the receiver must ignore it.
   task automatic send_frame();
      rxd = 1'b0;
      cyc(8);
      cfg_data_bits = 4'($urandom_range(0, 15));
      cfg_parity    = 2'($urandom_range(0, 3));
      cfg_stop_bits = 1'($urandom_range(0, 1));
      cyc(bit_clk - 8);
      for (int i = 0; i < fb_len; i++) begin
         rxd = fb[i][0];
         cyc(bit_clk);
      end
      rxd = 1'b1;
   endtask

   function automatic logic [DW+2:0] model(input int nbc, input int par,
                                           input int st);
      int nb, k, ones;
      logic [DW-1:0] d;
      bit allz, frm, perr;
      nb = (nbc < 5 || nbc > DW) ? DW : nbc;
      d = '0;
      ones = 0;
      allz = 1;
      frm = 0;
      perr = 0;
      k = 0;
      for (int i = 0; i < nb; i++) begin
         d[i] = fb[k][0];
         ones += fb[k];
         if (fb[k] != 0) allz = 0;
         k++;
      end
      if (par == 1 || par == 2) begin
         ones += fb[k];
         if (fb[k] != 0) allz = 0;
         perr = (par == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
         k++;
      end
      for (int s = 0; s <= st; s++) begin
         if (fb[k] == 0) frm = 1;
         else allz = 0;
         k++;
      end
      if (allz) return {3'b110, {DW{1'b0}}};
      return {1'b0, frm, perr, d};
   endfunction

   task automatic expect_word(input string tag, input logic [DW+2:0] exp,
                              input int base);
      int n;
      n = 0;
      while (got_n <= base && n < 8 * bit_clk) begin
         cyc(1);
         n++;
      end
      chk({tag, "_cnt"}, got_n, base + 1);
      chk({tag, "_word"}, got[base % 256], exp);
   endtask

   initial begin
      int base, nbc, nbe, par, st, data, ps;
      logic [DW+2:0] exp;

      rst = 1'b0;
      cyc(5);
      chk("rst_out", {m_axis_tvalid, m_axis_tuser, m_axis_tdata, busy,
                      overrun_error, frame_error, parity_error,
                      break_detect}, 32'd0);
      rst = 1'b1;
      m_axis_tready = 1'b1;
      cyc(20);
      chk("idle_busy", busy, 0);

      snap();
      base = got_n;
      set_cfg(8, 0, 0);
      build(8, 0, 0, 'hA5, 0, 0);
      send_frame();
      cyc(2 * bit_clk);
      expect_word("8n1", {3'b000, 9'h0A5}, base);
      chk("8n1_err", errs(), 32'h0);

      snap();
      base = got_n;
      set_cfg(7, 2, 0);
      build(7, 2, 0, 'h41, 1, 0);
      send_frame();
      cyc(2 * bit_clk);
      expect_word("7e1", {3'b001, 9'h041}, base);
      chk("7e1_err", errs(), 32'h0000_0001);

      snap();
      base = got_n;
      set_cfg(9, 1, 1);
      build(9, 1, 1, 'h1FF, 0, 1);
      send_frame();
      cyc(2 * bit_clk);
      expect_word("9o2", {3'b010, 9'h1FF}, base);
      chk("9o2_err", errs(), 32'h0000_0100);

      snap();
      base = got_n;
      set_cfg(8, 0, 0);
      rxd = 1'b0;
      cyc(20 * bit_clk);
      chk("brk_busy", busy, 1);
      expect_word("brk", {3'b110, 9'h000}, base);
      chk("brk_err", errs() & 32'hFFFF_00FF, 32'h0001_0000);
      rxd = 1'b1;
      cyc(8);
      chk("brk_idle", busy, 0);
      cyc(2 * bit_clk);
      chk("brk_once", got_n, base + 1);

      snap();
      base = got_n;
      m_axis_tready = 1'b0;
      set_cfg(8, 0, 0);
      build(8, 0, 0, 'h11, 0, 0);
      send_frame();
      set_cfg(8, 0, 0);
      build(8, 0, 0, 'h22, 0, 0);
      send_frame();
      cyc(2 * bit_clk);
      chk("ovr_err", errs(), 32'h0100_0000);
      chk("ovr_hold", {m_axis_tvalid, m_axis_tuser, m_axis_tdata},
          {1'b1, 3'b000, 9'h011});
      chk("ovr_none", got_n, base);
      m_axis_tready = 1'b1;
      cyc(2);
      expect_word("ovr", {3'b000, 9'h011}, base);
      chk("ovr_drain", m_axis_tvalid, 0);

      base = got_n;
      rxd = 1'b0;
      cyc(3);
      rxd = 1'b1;
      cyc(3 * bit_clk);
      chk("glitch_word", got_n, base);
      chk("glitch_busy", busy, 0);

      base = got_n;
      set_cfg(8, 0, 0);
      rxd = 1'b0;
      cyc(bit_clk);
      rxd = 1'b1;
      cyc(bit_clk);
      rxd = 1'b0;
      cyc(bit_clk / 2);
      chk("mid_busy", busy, 1);
      rst = 1'b0;
      rxd = 1'b1;
      cyc(3);
      chk("mid_rst", {m_axis_tvalid, m_axis_tuser, m_axis_tdata, busy,
                      overrun_error, frame_error, parity_error,
                      break_detect}, 32'd0);
      rst = 1'b1;
      cyc(2 * bit_clk);
      chk("mid_none", got_n, base);
      set_cfg(8, 0, 0);
      build(8, 0, 0, 'h5A, 0, 0);
      send_frame();
      cyc(2 * bit_clk);
      expect_word("post_rst", {3'b000, 9'h05A}, base);

      for (int it = 0; it < 16; it++) begin
         ps = $urandom_range(0, 5);
         cfg_prescale = 16'(ps);
         bit_clk = OS * ((ps == 0) ? 1 : ps);
         nbc = $urandom_range(0, 15);
         nbe = (nbc < 5 || nbc > DW) ? DW : nbc;
         par = $urandom_range(0, 3);
         st = $urandom_range(0, 1);
         data = $urandom_range(0, 511);
         cyc(2 * bit_clk);
         snap();
         base = got_n;
         build(nbe, par, st, data, $urandom_range(0, 3) == 0,
               $urandom_range(0, 3) == 0);
         set_cfg(nbc, par, st);
         exp = model(nbc, par, st);
         send_frame();
         cyc(2 * bit_clk);
         expect_word($sformatf("rnd%0d", it), exp, base);
         chk($sformatf("rnd%0d_err", it), errs(),
             {8'd0, 7'd0, exp[DW+2], 7'd0, exp[DW+1], 7'd0, exp[DW]});
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
